// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM arbiter and its round-robin picker.
package sram_bus_pkg;

  localparam int ADDRESS_WIDTH_DEFAULT = 16;
  localparam int DATA_WIDTH_DEFAULT    = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  // The port that should win a tie, given who was served last.
  function automatic logic other_port(input logic port);
    return (port == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// whichever port was not granted last.
module rr_arb2
  import sram_bus_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_sel
);

  always_comb begin
    grant_valid = a_req | b_req;
    grant_sel   = PORT_A;
    if (a_req && b_req) begin
      grant_sel = other_port(last_grant);
    end else if (b_req) begin
      grant_sel = PORT_B;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the CPU (A) and debug (B) buses onto one synchronous SRAM port,
// sequencing IDLE -> ACCESS -> RESP so the SRAM's negedge update lands inside ACCESS.
module sram_arbiter
  import sram_bus_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEFAULT,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     a_req,
  input  logic                     a_we,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_wdata,
  output logic                     a_ack,
  output logic [DATA_WIDTH-1:0]    a_rdata,
  input  logic                     b_req,
  input  logic                     b_we,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_wdata,
  output logic                     b_ack,
  output logic [DATA_WIDTH-1:0]    b_rdata,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_rd_en,
  output logic                     mem_wr_en,
  output logic [DATA_WIDTH-1:0]    mem_wr_data,
  input  logic [DATA_WIDTH-1:0]    mem_rd_data
);

  arb_state_t state;
  logic       last_grant;
  logic       gnt;
  logic       grant_valid;
  logic       grant_sel;

  logic                     sel_we;
  logic [ADDRESS_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]    sel_wdata;

  rr_arb2 u_rr_arb2 (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (grant_sel == PORT_B) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  // Enables are live for the whole ACCESS cycle only; the read enable doubles
  // as the "this was a read" flag when the access retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= PORT_B;
      gnt         <= PORT_A;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_rd_en   <= 1'b0;
      mem_wr_en   <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          a_ack     <= 1'b0;
          b_ack     <= 1'b0;
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b0;
          if (grant_valid) begin
            gnt         <= grant_sel;
            last_grant  <= grant_sel;
            mem_addr    <= sel_addr;
            mem_wr_data <= sel_wdata;
            mem_wr_en   <= sel_we;
            mem_rd_en   <= ~sel_we;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b0;
          if (gnt == PORT_A) begin
            a_ack <= 1'b1;
            if (mem_rd_en) a_rdata <= mem_rd_data;
          end else begin
            b_ack <= 1'b1;
            if (mem_rd_en) b_rdata <= mem_rd_data;
          end
          state <= RESP;
        end
        RESP: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          state <= IDLE;
        end
        default: begin
          a_ack     <= 1'b0;
          b_ack     <= 1'b0;
          mem_rd_en <= 1'b0;
          mem_wr_en <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a negedge-updating SRAM model behind it.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we;
  logic [15:0] a_addr, b_addr, mem_addr;
  logic [7:0]  a_wdata, b_wdata, a_rdata, b_rdata, mem_wr_data, mem_rd_data;
  logic        a_ack, b_ack, mem_rd_en, mem_wr_en;

  int checks = 0;
  int errors = 0;

  logic [7:0] sram [0:65535];

  int wr_cnt, rd_cnt, both_cnt, a_ack_cnt, b_ack_cnt;
  int a_run, b_run, max_run;
  logic [15:0] last_wr_addr;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_ack       (a_ack),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_ack       (b_ack),
    .b_rdata     (b_rdata),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // Synchronous SRAM: acts on the negedge, drives zero when not reading.
  always @(negedge clk) begin
    if (mem_wr_en) sram[mem_addr] <= mem_wr_data;
    mem_rd_data <= mem_rd_en ? sram[mem_addr] : 8'h00;
  end

  // Bus monitor: access counts, overlap of enables, ack pulse widths.
  always @(negedge clk) begin
    if (mem_rd_en && mem_wr_en) both_cnt++;
    if (mem_wr_en) begin
      wr_cnt++;
      last_wr_addr = mem_addr;
    end
    if (mem_rd_en) rd_cnt++;
    if (a_ack) a_ack_cnt++;
    if (b_ack) b_ack_cnt++;
    a_run = a_ack ? a_run + 1 : 0;
    b_run = b_ack ? b_run + 1 : 0;
    if (a_run > max_run) max_run = a_run;
    if (b_run > max_run) max_run = b_run;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [15:0] addr,
                               input logic [7:0] wdata);
    @(negedge clk);
    if (port == 1'b0) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata;
    end
  endtask

  // Returns the number of negedges until the port's ack is seen, -1 on timeout.
  task automatic wait_ack(input logic port, output int n);
    logic seen;
    n = -1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if ((port == 1'b0) ? a_ack : b_ack) begin
        n = i + 1;
        seen = 1'b1;
      end
    end
    if (!seen) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n, n2, a_done, b_done, wr0, rd0;
    logic [1:0] order [$];

    for (int i = 0; i < 65536; i++) sram[i] = 8'h00;
    sram[16'h0010] = 8'h11;
    sram[16'h0020] = 8'h22;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    reset = 1'b1;
    wr_cnt = 0; rd_cnt = 0; both_cnt = 0; a_ack_cnt = 0; b_ack_cnt = 0;
    a_run = 0; b_run = 0; max_run = 0; last_wr_addr = '0;

    do_reset();
    @(negedge clk);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_enables", {mem_rd_en, mem_wr_en}, 0);
    checkOutput("rst_acks", {a_ack, b_ack}, 0);
    checkOutput("rst_rdata", {a_rdata, b_rdata}, 0);
    checkOutput("rst_wr_data", mem_wr_data, 0);

    // A write then A read of the same address
    wr0 = wr_cnt;
    applyStimulus(1'b0, 1'b1, 16'h1234, 8'h5A);
    wait_ack(1'b0, n);
    a_req = 1'b0;
    checkOutput("t1_wr_lat", n, 2);
    checkOutput("t1_wr_count", wr_cnt - wr0, 1);
    checkOutput("t1_wr_addr", last_wr_addr, 16'h1234);
    applyStimulus(1'b0, 1'b0, 16'h1234, 8'h00);
    wait_ack(1'b0, n);
    a_req = 1'b0;
    checkOutput("t1_rd_lat", n, 2);
    checkOutput("t1_a_rdata", a_rdata, 8'h5A);
    checkOutput("t1_b_ack_none", b_ack_cnt, 0);

    // Simultaneous requests straight after reset: A first, B three cycles later
    do_reset();
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    b_req = 1; b_we = 0; b_addr = 16'h0020;
    a_done = -1; b_done = -1;
    for (int i = 0; i < 20 && (a_done < 0 || b_done < 0); i++) begin
      @(negedge clk);
      if (a_ack && a_done < 0) begin a_done = i; a_req = 0; end
      if (b_ack && b_done < 0) begin b_done = i; b_req = 0; end
    end
    checkOutput("t2_a_first", a_done, 1);
    checkOutput("t2_b_gap", b_done - a_done, 3);
    checkOutput("t2_a_rdata", a_rdata, 8'h11);
    checkOutput("t2_b_rdata", b_rdata, 8'h22);

    // Both ports hold req for six accesses: strict alternation
    both_cnt = 0;
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 16'h0010;
    b_req = 1; b_we = 0; b_addr = 16'h0020;
    for (int i = 0; i < 60 && order.size() < 6; i++) begin
      @(negedge clk);
      if (a_ack) order.push_back(2'd0);
      if (b_ack) order.push_back(2'd1);
      if (order.size() >= 6) begin a_req = 0; b_req = 0; end
    end
    a_req = 0; b_req = 0;
    checkOutput("t3_count", order.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < order.size()) checkOutput($sformatf("t3_order%0d", i), order[i], i % 2);
    end
    checkOutput("t3_no_overlap", both_cnt, 0);

    // B writes the top address, A reads it back; B's held data is untouched
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 8'hFF);
    wait_ack(1'b1, n);
    b_req = 1'b0;
    checkOutput("t4_b_lat", n, 2);
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 8'h00);
    wait_ack(1'b0, n);
    a_req = 1'b0;
    checkOutput("t4_a_rdata", a_rdata, 8'hFF);
    checkOutput("t4_b_rdata", b_rdata, 8'h22);

    // Reset while an A read sits in ACCESS
    applyStimulus(1'b0, 1'b0, 16'h0010, 8'h00);
    @(negedge clk);
    checkOutput("t5_in_access", mem_rd_en, 1);
    reset = 1'b1;
    a_req = 1'b0;
    @(negedge clk);
    checkOutput("t5_rd_en", mem_rd_en, 0);
    checkOutput("t5_a_ack", a_ack, 0);
    checkOutput("t5_a_rdata", a_rdata, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_no_late_ack", a_ack, 0);
    applyStimulus(1'b0, 1'b0, 16'h0020, 8'h00);
    wait_ack(1'b0, n);
    a_req = 1'b0;
    checkOutput("t5_lat", n, 2);
    checkOutput("t5_a_rdata_after", a_rdata, 8'h22);

    // Write then read, switching the request during the ack cycle
    wr0 = wr_cnt; rd0 = rd_cnt;
    applyStimulus(1'b0, 1'b1, 16'h0100, 8'h3C);
    wait_ack(1'b0, n);
    a_we = 1'b0;
    wait_ack(1'b0, n2);
    a_req = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t6_wr_lat", n, 2);
    checkOutput("t6_rd_lat", n2, 3);
    checkOutput("t6_wr_count", wr_cnt - wr0, 1);
    checkOutput("t6_rd_count", rd_cnt - rd0, 1);
    checkOutput("t6_a_rdata", a_rdata, 8'h3C);

    checkOutput("ack_width", max_run, 1);
    checkOutput("overlap_total", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
